sr_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the clocked `sr` flip-flop and drives its `s`/`r` inputs. It accepts set/reset requests over a valid/ready handshake, buffers them in a small FIFO, and plays each one out as a clean pulse of fixed width followed by an idle gap. It guarantees that `s` and `r` are never high together (the forbidden SR input), and it tracks the expected flip-flop state. Optionally, it checks that state against the flip-flop's `q` output.

---
 rtl/sr_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ctrl.sv
// sr_ctrl: command sequencer driving the s/r inputs of a clocked SR flip-flop.
// Requests (1 = set, 0 = reset) are buffered in a small FIFO and played out as
// a PULSE_W-cycle pulse on s or r followed by a GAP_W-cycle idle gap, so s and r
// are never high together. q_exp tracks the flip-flop state after the last
// issued command.
// Optional feature macro: SR_CTRL_CHECK_EN -- when defined, the flip-flop q is
// compared with q_exp on the last gap cycle and a sticky mismatch flag is set
// on disagreement. When undefined, q is ignored and mismatch is tied low.
module sr_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int DEPTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd,
    output logic cmd_ready,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_exp,
    input  logic q,
    output logic mismatch
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int MAX_W  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    // FIFO storage and bookkeeping
    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head;

    // Sequencer state and registered outputs
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_last;
    logic             gap_last;
    logic             s_q;
    logic             r_q;
    logic             q_exp_q;
    logic             busy_q;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = rst_n && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    assign pulse_last = (cnt_q == CNT_W'(PULSE_W - 1));
    assign gap_last   = (cnt_q == CNT_W'(GAP_W - 1));

    // The head is consumed whenever a new pulse is launched: from IDLE, or
    // straight out of the last gap cycle so back-to-back pulses have no idle.
    assign pop = !empty && ((state_q == ST_IDLE) || (state_q == ST_GAP && gap_last));

    // Next occupancy; push and pop together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO data write; push is already gated by rst_n through cmd_ready.
    // NOTE: storage entries carry no reset -- only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
    end

    // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

`ifdef SR_CTRL_CHECK_EN
    logic mismatch_q;
`else
    logic q_unused;
    assign q_unused = q;
`endif

    // Pulse sequencer: IDLE -> PULSE (PULSE_W cycles) -> GAP (GAP_W cycles) -> PULSE/IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_exp_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SR_CTRL_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_PULSE;
                        cnt_q   <= '0;
                        s_q     <= head;
                        r_q     <= !head;
                        q_exp_q <= head;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulse_last) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
`ifdef SR_CTRL_CHECK_EN
                        if (q != q_exp_q) begin
                            mismatch_q <= 1'b1;
                        end
`endif
                        if (pop) begin
                            state_q <= ST_PULSE;
                            cnt_q   <= '0;
                            s_q     <= head;
                            r_q     <= !head;
                            q_exp_q <= head;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            // A request arriving on this very edge keeps the block busy.
                            busy_q  <= push;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign s     = s_q;
    assign r     = r_q;
    assign q_exp = q_exp_q;
    assign busy  = busy_q;

`ifdef SR_CTRL_CHECK_EN
    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sr_ctrl.sv
// tb_sr_ctrl: directed self-checking bench for sr_ctrl (PULSE_W=2, GAP_W=1, DEPTH=4).
// A behavioural SR flip-flop closes the q loop; q can be forced low to provoke
// a mismatch. Pulse starts are logged in order for command-ordering checks.
module tb_sr_ctrl;

`ifdef SR_CTRL_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd       = 1'b0;
    logic q_force   = 1'b0;
    logic sr_q      = 1'b0;
    logic q_fb;
    logic cmd_ready;
    logic s;
    logic r;
    logic busy;
    logic q_exp;
    logic mismatch;

    int checks  = 0;
    int errors  = 0;
    int both_hi = 0;
    bit obs_q[$];
    logic s_prev = 1'b0;
    logic r_prev = 1'b0;

    bit v4 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit v6 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    assign q_fb = q_force ? 1'b0 : sr_q;

    sr_ctrl #(
        .PULSE_W(2),
        .GAP_W  (1),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .q_exp    (q_exp),
        .q        (q_fb),
        .mismatch (mismatch)
    );

    // Behavioural clocked SR flip-flop downstream of the sequencer.
    always @(posedge clk) begin
        if (s) sr_q <= 1'b1;
        else if (r) sr_q <= 1'b0;
    end

    // Monitor: forbidden s&&r and the order in which pulses start.
    always @(negedge clk) begin
        if (s && r) both_hi++;
        if (s && !s_prev) obs_q.push_back(1'b1);
        if (r && !r_prev) obs_q.push_back(1'b0);
        s_prev = s;
        r_prev = r;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_s",        {31'd0, s},         0);
        check("rst_r",        {31'd0, r},         0);
        check("rst_q_exp",    {31'd0, q_exp},     0);
        check("rst_busy",     {31'd0, busy},      0);
        check("rst_mismatch", {31'd0, mismatch},  0);
        check("rst_ready",    {31'd0, cmd_ready}, 0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", {31'd0, cmd_ready}, 1);
        check("rel_busy",  {31'd0, busy},      0);

        // ---------------- single set command ----------------
        cmd_valid = 1'b1;
        cmd = 1'b1;
        tick();                                   // E0: accepted
        cmd_valid = 1'b0;
        check("t1_s_e0", {31'd0, s}, 0);
        tick();                                   // E0+1
        check("t1_s_e1",    {31'd0, s},     1);
        check("t1_r_e1",    {31'd0, r},     0);
        check("t1_qexp_e1", {31'd0, q_exp}, 1);
        check("t1_busy_e1", {31'd0, busy},  1);
        tick();                                   // E0+2
        check("t1_s_e2", {31'd0, s}, 1);
        check("t1_r_e2", {31'd0, r}, 0);
        tick();                                   // E0+3
        check("t1_s_e3",    {31'd0, s},    0);
        check("t1_busy_e3", {31'd0, busy}, 1);
        tick();                                   // E0+4: gap over, back to idle
        check("t1_busy_e4", {31'd0, busy},     0);
        check("t1_mm",      {31'd0, mismatch}, 0);

        // ---------------- burst 1,0,1,0 ----------------
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd = v4[i];
            check($sformatf("b4_ready%0d", i), {31'd0, cmd_ready}, 1);
            tick();                               // E0+i
        end
        cmd_valid = 1'b0;
        tick();                                   // E0+4
        check("b4_r_e4",    {31'd0, r},     1);
        check("b4_s_e4",    {31'd0, s},     0);
        check("b4_qexp_e4", {31'd0, q_exp}, 0);
        repeat (3) tick();                        // E0+7
        check("b4_s_e7",    {31'd0, s},     1);
        check("b4_qexp_e7", {31'd0, q_exp}, 1);
        repeat (3) tick();                        // E0+10
        check("b4_r_e10",    {31'd0, r},     1);
        check("b4_qexp_e10", {31'd0, q_exp}, 0);
        wait_idle("b4_idle", 20);
        check("b4_count", obs_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_q.size()) check($sformatf("b4_order%0d", i), {31'd0, obs_q[i]}, {31'd0, v4[i]});
        end

        // ---------------- burst of 6, FIFO fills ----------------
        obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd = v6[i];
            check($sformatf("b6_ready%0d", i), {31'd0, cmd_ready}, 1);
            tick();
        end
        check("b6_full_ready", {31'd0, cmd_ready}, 0);
        cmd_valid = 1'b0;
        wait_idle("b6_idle", 60);
        check("b6_count", obs_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_q.size()) check($sformatf("b6_order%0d", i), {31'd0, obs_q[i]}, {31'd0, v6[i]});
        end
        check("b6_qexp", {31'd0, q_exp},    0);
        check("b6_mm",   {31'd0, mismatch}, 0);

        // ---------------- reset during second cycle of an r pulse ----------------
        cmd_valid = 1'b1;
        cmd = 1'b1; tick();                       // E0
        cmd = 1'b0; tick();                       // E1
        cmd = 1'b1; tick();                       // E2
        cmd_valid = 1'b0;
        tick();                                   // E3 (gap)
        tick();                                   // E4
        check("mr_r_first", {31'd0, r}, 1);
        tick();                                   // E5
        check("mr_r_second", {31'd0, r}, 1);
        rst_n = 1'b0;
        tick();                                   // E6: reset edge
        check("mr_s",     {31'd0, s},         0);
        check("mr_r",     {31'd0, r},         0);
        check("mr_qexp",  {31'd0, q_exp},     0);
        check("mr_busy",  {31'd0, busy},      0);
        check("mr_ready", {31'd0, cmd_ready}, 0);
        rst_n = 1'b1;
        tick();
        check("mr_rel_busy",  {31'd0, busy},      0);
        check("mr_rel_ready", {31'd0, cmd_ready}, 1);
        tick();
        check("mr_rel_s",     {31'd0, s},    0);
        check("mr_rel_busy2", {31'd0, busy}, 0);
        cmd_valid = 1'b1;
        cmd = 1'b0;
        tick();                                   // accepted from IDLE
        cmd_valid = 1'b0;
        tick();
        check("mr_new_r", {31'd0, r}, 1);
        check("mr_new_s", {31'd0, s}, 0);
        wait_idle("mr_idle", 20);

        // ---------------- mismatch detection ----------------
        check("mm_clean", {31'd0, mismatch}, 0);
        q_force = 1'b1;
        cmd_valid = 1'b1;
        cmd = 1'b1;
        tick();                                   // E0
        cmd_valid = 1'b0;
        repeat (3) tick();                        // E0+3: still in gap
        check("mm_before_gap_end", {31'd0, mismatch}, 0);
        tick();                                   // E0+4: gap end compare
        check("mm_set", {31'd0, mismatch}, {31'd0, CHECK_ON});
        q_force = 1'b0;
        repeat (4) tick();
        check("mm_sticky", {31'd0, mismatch}, {31'd0, CHECK_ON});
        rst_n = 1'b0;
        tick();
        check("mm_rst", {31'd0, mismatch}, 0);
        rst_n = 1'b1;
        tick();

        check("s_r_never_both", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
